// File: rtl/butterfly_dif_pipe.sv
// butterfly_dif_pipe
// Pipelined radix-2 decimation-in-frequency (Gentleman-Sande) butterfly in Q1.15 by default:
//   X = a + b,  Y = (a - b) * W   (W optionally conjugated per beat for inverse transforms)
// Three register stages (sum/diff, products, round+saturate) share one stall enable, so a
// stalled output freezes the whole pipe. Round-half-up, saturation and a sticky ovf flag.
//
// Optional feature: define BFLY_SCALE_EN to scale both outputs by 1/2 (same latency).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake (beat accepted when both high)
//   a_*, b_*, w_*     operands and twiddle (signed, WIDTH bits)
//   inv               per-beat: use conj(W)
//   out_valid/out_ready output handshake
//   X_*, Y_*          sum and twiddled-difference outputs
//   ovf, ovf_clr      sticky saturation flag and its clear (set wins over clear)
module butterfly_dif_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = WIDTH - 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a_re,
    input  logic signed [WIDTH-1:0] a_im,
    input  logic signed [WIDTH-1:0] b_re,
    input  logic signed [WIDTH-1:0] b_im,
    input  logic signed [WIDTH-1:0] w_re,
    input  logic signed [WIDTH-1:0] w_im,
    input  logic                    inv,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] X_re,
    output logic signed [WIDTH-1:0] X_im,
    output logic signed [WIDTH-1:0] Y_re,
    output logic signed [WIDTH-1:0] Y_im,
    output logic                    ovf,
    input  logic                    ovf_clr
);

    localparam int unsigned SW = WIDTH + 1;      // sum/diff width
    localparam int unsigned PW = 2 * WIDTH + 2;  // product width
    localparam int unsigned RW = PW + 1;         // headroom for the rounding add

`ifdef BFLY_SCALE_EN
    localparam int unsigned Y_SH = FRAC + 1;
    localparam int unsigned X_SH = 1;
`else
    localparam int unsigned Y_SH = FRAC;
    localparam int unsigned X_SH = 0;
`endif

    localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [RW-1:0]    Y_RND = {{(RW-1){1'b0}}, 1'b1} << (Y_SH - 1);

    // Returns {clamped, value}.
    function automatic logic [WIDTH:0] sat(input logic signed [RW-1:0] v);
        if (v > RW'(S_MAX)) begin
            return {1'b1, S_MAX};
        end else if (v < RW'(S_MIN)) begin
            return {1'b1, S_MIN};
        end else begin
            return {1'b0, v[WIDTH-1:0]};
        end
    endfunction

    // Stage 1 registers
    logic                    v1_q, v1_d;
    logic signed [SW-1:0]    sum1_re_q, sum1_re_d, sum1_im_q, sum1_im_d;
    logic signed [SW-1:0]    diff_re_q, diff_re_d, diff_im_q, diff_im_d;
    logic signed [WIDTH-1:0] tw_re_q, tw_re_d, tw_im_q, tw_im_d;
    // Stage 2 registers
    logic                    v2_q, v2_d;
    logic signed [SW-1:0]    sum2_re_q, sum2_re_d, sum2_im_q, sum2_im_d;
    logic signed [PW-1:0]    pr_q, pr_d, pi_q, pi_d;
    // Stage 3 (output) registers
    logic                    out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0] x_re_q, x_re_d, x_im_q, x_im_d;
    logic signed [WIDTH-1:0] y_re_q, y_re_d, y_im_q, y_im_d;
    logic                    ovf_q, ovf_d;

    logic                    adv;
    logic signed [WIDTH-1:0] tw_im_in;
    logic signed [PW-1:0]    dr_x, di_x, wr_x, wi_x;
    logic signed [RW-1:0]    xr_w, xi_w, yr_w, yi_w;
    logic [WIDTH:0]          xr_s, xi_s, yr_s, yi_s;
    logic                    clamp;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv && !rst;

    // Stage 1: wide sum/diff and (optionally conjugated) twiddle.
    always_comb begin
        tw_im_in = w_im;
        if (inv) begin
            // -(-2^(W-1)) is not representable; clamp it to the positive maximum.
            tw_im_in = (w_im == S_MIN) ? S_MAX : -w_im;
        end
        v1_d      = v1_q;
        sum1_re_d = sum1_re_q;
        sum1_im_d = sum1_im_q;
        diff_re_d = diff_re_q;
        diff_im_d = diff_im_q;
        tw_re_d   = tw_re_q;
        tw_im_d   = tw_im_q;
        if (adv) begin
            v1_d      = in_valid;
            sum1_re_d = {a_re[WIDTH-1], a_re} + {b_re[WIDTH-1], b_re};
            sum1_im_d = {a_im[WIDTH-1], a_im} + {b_im[WIDTH-1], b_im};
            diff_re_d = {a_re[WIDTH-1], a_re} - {b_re[WIDTH-1], b_re};
            diff_im_d = {a_im[WIDTH-1], a_im} - {b_im[WIDTH-1], b_im};
            tw_re_d   = w_re;
            tw_im_d   = tw_im_in;
        end
    end

    // Stage 2: full-precision complex product; sum travels alongside.
    always_comb begin
        dr_x      = PW'(diff_re_q);
        di_x      = PW'(diff_im_q);
        wr_x      = PW'(tw_re_q);
        wi_x      = PW'(tw_im_q);
        v2_d      = v2_q;
        sum2_re_d = sum2_re_q;
        sum2_im_d = sum2_im_q;
        pr_d      = pr_q;
        pi_d      = pi_q;
        if (adv) begin
            v2_d      = v1_q;
            sum2_re_d = sum1_re_q;
            sum2_im_d = sum1_im_q;
            pr_d      = dr_x * wr_x - di_x * wi_x;
            pi_d      = dr_x * wi_x + di_x * wr_x;
        end
    end

    // Stage 3: round-half-up, arithmetic shift, saturate; sticky overflow.
    always_comb begin
        xr_w = RW'(sum2_re_q);
        xi_w = RW'(sum2_im_q);
        if (X_SH != 0) begin
            xr_w = (xr_w + RW'(1)) >>> X_SH;
            xi_w = (xi_w + RW'(1)) >>> X_SH;
        end
        yr_w  = (RW'(pr_q) + Y_RND) >>> Y_SH;
        yi_w  = (RW'(pi_q) + Y_RND) >>> Y_SH;
        xr_s  = sat(xr_w);
        xi_s  = sat(xi_w);
        yr_s  = sat(yr_w);
        yi_s  = sat(yi_w);
        clamp = xr_s[WIDTH] | xi_s[WIDTH] | yr_s[WIDTH] | yi_s[WIDTH];

        out_valid_d = out_valid_q;
        x_re_d      = x_re_q;
        x_im_d      = x_im_q;
        y_re_d      = y_re_q;
        y_im_d      = y_im_q;
        ovf_d       = ovf_clr ? 1'b0 : ovf_q;
        if (adv) begin
            out_valid_d = v2_q;
            // Data only loads for real beats so bubbles leave the last outputs in place.
            if (v2_q) begin
                x_re_d = xr_s[WIDTH-1:0];
                x_im_d = xi_s[WIDTH-1:0];
                y_re_d = yr_s[WIDTH-1:0];
                y_im_d = yi_s[WIDTH-1:0];
                if (clamp) begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            sum1_re_q   <= '0;
            sum1_im_q   <= '0;
            diff_re_q   <= '0;
            diff_im_q   <= '0;
            tw_re_q     <= '0;
            tw_im_q     <= '0;
            v2_q        <= 1'b0;
            sum2_re_q   <= '0;
            sum2_im_q   <= '0;
            pr_q        <= '0;
            pi_q        <= '0;
            out_valid_q <= 1'b0;
            x_re_q      <= '0;
            x_im_q      <= '0;
            y_re_q      <= '0;
            y_im_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            sum1_re_q   <= sum1_re_d;
            sum1_im_q   <= sum1_im_d;
            diff_re_q   <= diff_re_d;
            diff_im_q   <= diff_im_d;
            tw_re_q     <= tw_re_d;
            tw_im_q     <= tw_im_d;
            v2_q        <= v2_d;
            sum2_re_q   <= sum2_re_d;
            sum2_im_q   <= sum2_im_d;
            pr_q        <= pr_d;
            pi_q        <= pi_d;
            out_valid_q <= out_valid_d;
            x_re_q      <= x_re_d;
            x_im_q      <= x_im_d;
            y_re_q      <= y_re_d;
            y_im_q      <= y_im_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign X_re      = x_re_q;
    assign X_im      = x_im_q;
    assign Y_re      = y_re_q;
    assign Y_im      = y_im_q;
    assign ovf       = ovf_q;

endmodule
